video_ctrl_sequencer: RTL and testbench
=======================================

VIDEO_CTRL_SEQUENCER -- requirements
Module: video_ctrl_sequencer

Interface
REQ-001 SHALL provide parameter HOLD_CYCLES, default 2: cycles each op is driven on the control bus (range 1-15).
REQ-002 SHALL provide parameter PAL_DEPTH, default 4: palette FIFO depth (power of 2, at least 2).
REQ-003 m_axis_vid_aclk  in  1  sole clock; all logic on its rising edge.
REQ-004 aresetn  in  1  asynchronous, active-low reset.
REQ-005 mode_valid  in  1  mode-change request; mode_ready  out  1  accept; transfer on valid&&ready.
REQ-006 mode_dims  in  32  {height[31:16], width[15:0]}; mode_max, mode_hs, mode_vs  in  32 each  {v/start[31:16], h/end[15:0]}.
REQ-007 mode_colormode  in  2; mode_scale  in  2  {scale_y, scale_x}; mode_thresh  in  16.
REQ-008 pal_valid  in  1; pal_ready  out  1; pal_index  in  8; pal_rgb  in  24  palette write request.
REQ-009 control_op  out  8; control_data  out  32  control bus to the video output block.
REQ-010 busy  out  1  high whenever the state is not IDLE or the FIFO is non-empty.

Function
REQ-011 Op codes: NOP=0, COLORMODE=1, DIMENSIONS=2, PALETTE=3, SCALE=4, VSYNC=5, MAX=6, HS=7, VS=8, THRESH=9.
REQ-012 Slot = op and data held stable for HOLD_CYCLES cycles, then control_op=0 (data unchanged) for 1 cycle; slot length HOLD_CYCLES+1.
REQ-013 control_op SHALL be 0 whenever no slot is active.
REQ-014 States: INIT, IDLE, MODE, PAL.
REQ-015 INIT (entered from reset): issue one slot VSYNC with data 0, then go to IDLE.
REQ-016 mode_ready = 1 only in IDLE; on accept, all mode_* fields are captured into shadow registers and the state goes to MODE.
REQ-017 MODE issues these slots back-to-back, in order: VSYNC data=1; DIMENSIONS data=dims; COLORMODE data={30'b0,colormode}; SCALE data={30'b0,scale}; MAX; HS; VS; THRESH data={16'b0,thresh}; VSYNC data=0. Then the state goes to IDLE.
REQ-018 The first MODE slot's op SHALL appear on the cycle after the accept edge; a full sequence is 9*(HOLD_CYCLES+1) cycles.
REQ-019 Mode_* input changes after accept SHALL NOT affect the running sequence.
REQ-020 Palette FIFO: pal_ready = !full; push on pal_valid&&pal_ready in any state except INIT.
REQ-021 In IDLE with FIFO non-empty and no mode_valid: pop one entry, enter PAL, issue one slot PALETTE data={index, rgb}, return to IDLE.
REQ-022 Priority: mode_valid in IDLE wins over a non-empty FIFO; palette entries are never interleaved inside a MODE sequence.
REQ-023 Push and pop in the same cycle SHALL keep the count unchanged and data in order; the FIFO read/write pointers wrap modulo PAL_DEPTH.
REQ-024 With the FIFO full, pal_ready = 0 and pal_valid is ignored; no overwrite.
REQ-025 The FIFO count SHALL never underflow; no pop occurs when empty.
REQ-026 At most one slot is active at any time.
REQ-027 control_op and control_data SHALL be registered outputs.

Reset
REQ-028 While aresetn=0: control_op=0, control_data=0, mode_ready=0, pal_ready=0, busy=1, FIFO emptied, state=INIT, slot counter=0.
REQ-029 Reset asserted mid-slot or mid-sequence SHALL abort it immediately; the INIT VSYNC=0 slot after release guarantees the sink's vsync request is cleared.

Verification
REQ-030 Reset release, HOLD=2 -> op 5/data 0 for 2 cycles, op 0 for 1 cycle, then mode_ready=1 and busy=0.
REQ-031 Mode request with dims=0x02D00500, colormode=2, thresh=0x10 -> ops 5,2,1,4,6,7,8,9,5 each held 2 cycles with 1-cycle NOP gaps, 27 cycles total; DIMENSIONS data=0x02D00500.
REQ-032 Five palette pushes back-to-back, PAL_DEPTH=4, while MODE runs -> 4 accepted, pal_ready=0 on the 5th; after the sequence, four op-3 slots in push order, e.g. data 0x01FF0000 first.
REQ-033 mode_valid and a non-empty FIFO both present in IDLE -> mode accepted first; palette slots follow the final VSYNC=0 slot.
REQ-034 aresetn pulsed low during the SCALE slot -> bus goes to 0 asynchronously; after release INIT issues VSYNC=0, then IDLE; the FIFO is empty.
REQ-035 FIFO at count 3, push and pop in the same cycle -> count stays 3, pal_ready stays 1, pop order preserved.

Source files
------------

// File: rtl/video_ctrl_sequencer.sv
// Control-bus sequencer for a video output block.
// Issues a VSYNC=0 slot after reset, then serves mode-change requests
// (a fixed nine-slot programming sequence) and queued palette writes
// (one PALETTE slot per entry). Each slot drives op/data for
// HOLD_CYCLES cycles followed by one NOP cycle with data held.
module video_ctrl_sequencer #(
    parameter int HOLD_CYCLES = 2,
    parameter int PAL_DEPTH   = 4
) (
    input  logic        m_axis_vid_aclk,
    input  logic        aresetn,
    input  logic        mode_valid,
    output logic        mode_ready,
    input  logic [31:0] mode_dims,
    input  logic [31:0] mode_max,
    input  logic [31:0] mode_hs,
    input  logic [31:0] mode_vs,
    input  logic [1:0]  mode_colormode,
    input  logic [1:0]  mode_scale,
    input  logic [15:0] mode_thresh,
    input  logic        pal_valid,
    output logic        pal_ready,
    input  logic [7:0]  pal_index,
    input  logic [23:0] pal_rgb,
    output logic [7:0]  control_op,
    output logic [31:0] control_data,
    output logic        busy
);

    localparam logic [7:0] OP_NOP       = 8'd0;
    localparam logic [7:0] OP_COLORMODE = 8'd1;
    localparam logic [7:0] OP_DIMENSION = 8'd2;
    localparam logic [7:0] OP_PALETTE   = 8'd3;
    localparam logic [7:0] OP_SCALE     = 8'd4;
    localparam logic [7:0] OP_VSYNC     = 8'd5;
    localparam logic [7:0] OP_MAX       = 8'd6;
    localparam logic [7:0] OP_HS        = 8'd7;
    localparam logic [7:0] OP_VS        = 8'd8;
    localparam logic [7:0] OP_THRESH    = 8'd9;

    localparam logic [3:0] HOLD_L  = 4'(HOLD_CYCLES);
    localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] LAST_STEP = 4'd8;

    localparam int PW = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_L = (PW+1)'(PAL_DEPTH);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_MODE, ST_PAL} state_t;

    state_t      state_q, state_d;
    logic        active_q, active_d;   // a slot is currently on the bus
    logic [3:0]  cnt_q, cnt_d;         // cycle within the current slot
    logic [3:0]  step_q, step_d;       // slot index within a MODE sequence
    logic [7:0]  op_q, op_d;
    logic [31:0] data_q, data_d;

    // Shadow copy of the accepted mode request
    logic [31:0] sh_dims_q, sh_max_q, sh_hs_q, sh_vs_q;
    logic [1:0]  sh_cm_q, sh_scale_q;
    logic [15:0] sh_thresh_q;
    logic        capture;

    // Palette FIFO
    logic [31:0]   mem_q [PAL_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          fifo_full, fifo_empty, push, pop;

    logic        slot_done;
    logic [3:0]  nstep;
    logic [7:0]  nxt_op;
    logic [31:0] nxt_data;

    assign fifo_full  = (count_q == DEPTH_L);
    assign fifo_empty = (count_q == '0);
    assign push       = pal_valid && pal_ready;
    assign slot_done  = active_q && (cnt_q == HOLD_L);
    assign nstep      = step_q + 4'd1;

    assign control_op   = op_q;
    assign control_data = data_q;

    // State register and registered control bus
    always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_INIT;
            active_q <= 1'b0;
            cnt_q    <= '0;
            step_q   <= '0;
            op_q     <= OP_NOP;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            op_q     <= op_d;
            data_q   <= data_d;
        end
    end

    // Op and data of the next slot in the mode programming sequence
    always_comb begin
        nxt_op   = OP_NOP;
        nxt_data = '0;
        case (nstep)
            4'd1: begin nxt_op = OP_DIMENSION; nxt_data = sh_dims_q;               end
            4'd2: begin nxt_op = OP_COLORMODE; nxt_data = {30'b0, sh_cm_q};        end
            4'd3: begin nxt_op = OP_SCALE;     nxt_data = {30'b0, sh_scale_q};     end
            4'd4: begin nxt_op = OP_MAX;       nxt_data = sh_max_q;                end
            4'd5: begin nxt_op = OP_HS;        nxt_data = sh_hs_q;                 end
            4'd6: begin nxt_op = OP_VS;        nxt_data = sh_vs_q;                 end
            4'd7: begin nxt_op = OP_THRESH;    nxt_data = {16'b0, sh_thresh_q};    end
            4'd8: begin nxt_op = OP_VSYNC;     nxt_data = 32'd0;                   end
            default: begin nxt_op = OP_NOP;    nxt_data = '0;                      end
        endcase
    end

    // Next-state logic: slot timing, arbitration and sequence stepping
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        op_d     = op_q;
        data_d   = data_q;
        capture  = 1'b0;
        pop      = 1'b0;

        // Running slot: hold op, then drop to NOP for the final cycle
        if (active_q && !slot_done) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == HOLD_M1) op_d = OP_NOP;
        end

        case (state_q)
            ST_INIT: begin
                if (!active_q) begin
                    active_d = 1'b1;
                    cnt_d    = '0;
                    op_d     = OP_VSYNC;
                    data_d   = 32'd0;
                end else if (slot_done) begin
                    active_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Mode requests take priority over pending palette writes
                if (mode_valid) begin
                    capture  = 1'b1;
                    state_d  = ST_MODE;
                    step_d   = '0;
                    active_d = 1'b1;
                    cnt_d    = '0;
                    op_d     = OP_VSYNC;
                    data_d   = 32'd1;
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_d  = ST_PAL;
                    active_d = 1'b1;
                    cnt_d    = '0;
                    op_d     = OP_PALETTE;
                    data_d   = mem_q[rd_ptr_q];
                end
            end
            ST_MODE: begin
                if (slot_done) begin
                    if (step_q == LAST_STEP) begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                        cnt_d    = '0;
                    end else begin
                        step_d = nstep;
                        cnt_d  = '0;
                        op_d   = nxt_op;
                        data_d = nxt_data;
                    end
                end
            end
            ST_PAL: begin
                if (slot_done) begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Handshake and status outputs decoded from state and FIFO level
    always_comb begin
        mode_ready = (state_q == ST_IDLE);
        pal_ready  = (state_q != ST_INIT) && !fifo_full;
        busy       = (state_q != ST_IDLE) || !fifo_empty;
    end

    // Mode request shadow capture on accept
    always_ff @(posedge m_axis_vid_aclk) begin
        if (capture) begin
            sh_dims_q   <= mode_dims;
            sh_max_q    <= mode_max;
            sh_hs_q     <= mode_hs;
            sh_vs_q     <= mode_vs;
            sh_cm_q     <= mode_colormode;
            sh_scale_q  <= mode_scale;
            sh_thresh_q <= mode_thresh;
        end
    end

    // Palette FIFO storage
    always_ff @(posedge m_axis_vid_aclk) begin
        if (push) mem_q[wr_ptr_q] <= {pal_index, pal_rgb};
    end

    // Palette FIFO pointers and occupancy
    always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_video_ctrl_sequencer.sv
// Bench for video_ctrl_sequencer: directed vector table, hand-written
// reset/FIFO corner sequences, then randomized traffic against a
// queue-based model of the expected control-bus stream.
module tb_video_ctrl_sequencer;

    localparam int HOLD  = 2;
    localparam int DEPTH = 4;

    localparam logic [31:0] DIMS = 32'h02D00500;
    localparam logic [1:0]  CM   = 2'd2;
    localparam logic [1:0]  SC   = 2'b01;
    localparam logic [31:0] MAXV = 32'h03200672;
    localparam logic [31:0] HSV  = 32'h02E40530;
    localparam logic [31:0] VSV  = 32'h02EA02E5;
    localparam logic [15:0] THR  = 16'h0010;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        mode_valid, mode_ready;
    logic [31:0] mode_dims, mode_max, mode_hs, mode_vs;
    logic [1:0]  mode_colormode, mode_scale;
    logic [15:0] mode_thresh;
    logic        pal_valid, pal_ready;
    logic [7:0]  pal_index;
    logic [23:0] pal_rgb;
    logic [7:0]  control_op;
    logic [31:0] control_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    video_ctrl_sequencer #(.HOLD_CYCLES(HOLD), .PAL_DEPTH(DEPTH)) dut (
        .m_axis_vid_aclk(clk),
        .aresetn        (aresetn),
        .mode_valid     (mode_valid),
        .mode_ready     (mode_ready),
        .mode_dims      (mode_dims),
        .mode_max       (mode_max),
        .mode_hs        (mode_hs),
        .mode_vs        (mode_vs),
        .mode_colormode (mode_colormode),
        .mode_scale     (mode_scale),
        .mode_thresh    (mode_thresh),
        .pal_valid      (pal_valid),
        .pal_ready      (pal_ready),
        .pal_index      (pal_index),
        .pal_rgb        (pal_rgb),
        .control_op     (control_op),
        .control_data   (control_data),
        .busy           (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The bus is modelled as a queue of per-cycle {op,data} values still to
    // appear; a request is accepted only once that queue has fully drained.
    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] data;
    } bus_t;

    bus_t        mq[$];
    logic [31:0] pq[$];
    bus_t        m_b;
    bit          m_show, m_init, m_idle, m_prdy;
    logic [7:0]  m_op;
    logic [31:0] m_data;

    task automatic m_slot(input logic [7:0] op, input logic [31:0] d);
        for (int i = 0; i < HOLD; i++) mq.push_back({op, d});
        mq.push_back({8'd0, d});
    endtask

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mq.delete();
            pq.delete();
            m_slot(8'd5, 32'd0);
            m_show = 1'b0;
            m_init = 1'b1;
            m_op   = 8'd0;
            m_data = 32'd0;
        end else begin
            m_idle = (mq.size() == 0) && !m_show;
            m_prdy = !m_init && (pq.size() < DEPTH);
            if (m_idle && mode_valid) begin
                m_slot(8'd5, 32'd1);
                m_slot(8'd2, mode_dims);
                m_slot(8'd1, {30'b0, mode_colormode});
                m_slot(8'd4, {30'b0, mode_scale});
                m_slot(8'd6, mode_max);
                m_slot(8'd7, mode_hs);
                m_slot(8'd8, mode_vs);
                m_slot(8'd9, {16'b0, mode_thresh});
                m_slot(8'd5, 32'd0);
            end else if (m_idle && pq.size() > 0) begin
                m_slot(8'd3, pq.pop_front());
            end
            if (pal_valid && m_prdy) pq.push_back({pal_index, pal_rgb});
            if (mq.size() > 0) begin
                m_b    = mq.pop_front();
                m_op   = m_b.op;
                m_data = m_b.data;
                m_show = 1'b1;
            end else begin
                m_op   = 8'd0;
                m_show = 1'b0;
            end
            if (mq.size() == 0 && !m_show) m_init = 1'b0;
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        mv;
        logic        pv;
        logic [7:0]  idx;
        logic [23:0] rgb;
        logic [7:0]  op;
        logic [31:0] data;
        logic        mr;
        logic        pr;
        logic        bsy;
    } vec_t;

    vec_t        tbl[$];
    logic [7:0]  sop[9];
    logic [31:0] sdat[9];

    task automatic rec(input logic [7:0] op, input logic [31:0] d, input logic mr,
                       input logic pr, input logic b, input logic mv, input logic pv,
                       input logic [7:0] idx, input logic [23:0] rgb);
        vec_t v;
        v.mv = mv; v.pv = pv; v.idx = idx; v.rgb = rgb;
        v.op = op; v.data = d; v.mr = mr; v.pr = pr; v.bsy = b;
        tbl.push_back(v);
    endtask

    task automatic tslot(input logic [7:0] op, input logic [31:0] d, input logic pr, input logic b);
        for (int i = 0; i < HOLD; i++) rec(op, d, 1'b0, pr, b, 1'b0, 1'b0, 8'd0, 24'd0);
        rec(8'd0, d, 1'b0, pr, b, 1'b0, 1'b0, 8'd0, 24'd0);
    endtask

    task automatic tmode(input int from, input logic pr, input logic b);
        for (int s = from; s < 9; s++) tslot(sop[s], sdat[s], pr, b);
    endtask

    logic [31:0] got_v[3];
    logic [31:0] exp_v[3];
    int          got;
    logic [7:0]  prev_op;
    bit          found;

    initial begin
        aresetn = 1'b0;
        mode_valid = 1'b0; pal_valid = 1'b0; pal_index = '0; pal_rgb = '0;
        mode_dims = DIMS; mode_max = MAXV; mode_hs = HSV; mode_vs = VSV;
        mode_colormode = CM; mode_scale = SC; mode_thresh = THR;

        sop[0] = 8'd5; sdat[0] = 32'd1;
        sop[1] = 8'd2; sdat[1] = DIMS;
        sop[2] = 8'd1; sdat[2] = 32'd2;
        sop[3] = 8'd4; sdat[3] = 32'd1;
        sop[4] = 8'd6; sdat[4] = MAXV;
        sop[5] = 8'd7; sdat[5] = HSV;
        sop[6] = 8'd8; sdat[6] = VSV;
        sop[7] = 8'd9; sdat[7] = 32'h10;
        sop[8] = 8'd5; sdat[8] = 32'd0;

        // op, data, mode_ready, pal_ready, busy | mode_valid, pal_valid, index, rgb
        rec(8'd5, 32'd0, 0, 0, 1, 0, 0, 8'h00, 24'h000000);
        rec(8'd5, 32'd0, 0, 0, 1, 0, 0, 8'h00, 24'h000000);
        rec(8'd0, 32'd0, 0, 0, 1, 0, 0, 8'h00, 24'h000000);
        rec(8'd0, 32'd0, 1, 1, 0, 1, 0, 8'h00, 24'h000000);
        rec(8'd5, 32'd1, 0, 1, 1, 0, 1, 8'h01, 24'hFF0000);
        rec(8'd5, 32'd1, 0, 1, 1, 0, 1, 8'h02, 24'h00FF00);
        rec(8'd0, 32'd1, 0, 1, 1, 0, 1, 8'h03, 24'h0000FF);
        rec(8'd2, DIMS,  0, 1, 1, 0, 1, 8'h04, 24'hFFFFFF);
        rec(8'd2, DIMS,  0, 0, 1, 0, 1, 8'h05, 24'h123456);
        rec(8'd0, DIMS,  0, 0, 1, 0, 0, 8'h00, 24'h000000);
        tmode(2, 1'b0, 1'b1);
        rec(8'd0, 32'd0, 1, 0, 1, 0, 0, 8'h00, 24'h000000);
        tslot(8'd3, 32'h01FF0000, 1'b1, 1'b1);
        rec(8'd0, 32'h01FF0000, 1, 1, 1, 1, 0, 8'h00, 24'h000000);
        tmode(0, 1'b1, 1'b1);
        rec(8'd0, 32'd0, 1, 1, 1, 0, 0, 8'h00, 24'h000000);
        tslot(8'd3, 32'h0200FF00, 1'b1, 1'b1);
        rec(8'd0, 32'h0200FF00, 1, 1, 1, 0, 0, 8'h00, 24'h000000);
        tslot(8'd3, 32'h030000FF, 1'b1, 1'b1);
        rec(8'd0, 32'h030000FF, 1, 1, 1, 0, 0, 8'h00, 24'h000000);
        tslot(8'd3, 32'h04FFFFFF, 1'b1, 1'b1);
        rec(8'd0, 32'h04FFFFFF, 1, 1, 0, 0, 0, 8'h00, 24'h000000);
        rec(8'd0, 32'h04FFFFFF, 1, 1, 0, 0, 0, 8'h00, 24'h000000);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.op", 32'(control_op), 32'd0);
        chk("rst.data", control_data, 32'd0);
        chk("rst.mode_ready", 32'(mode_ready), 32'd0);
        chk("rst.pal_ready", 32'(pal_ready), 32'd0);
        chk("rst.busy", 32'(busy), 32'd1);
        aresetn = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            chk($sformatf("vec%0d.op", i), 32'(control_op), 32'(tbl[i].op));
            chk($sformatf("vec%0d.data", i), control_data, tbl[i].data);
            chk($sformatf("vec%0d.mode_ready", i), 32'(mode_ready), 32'(tbl[i].mr));
            chk($sformatf("vec%0d.pal_ready", i), 32'(pal_ready), 32'(tbl[i].pr));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].bsy));
            mode_valid = tbl[i].mv;
            pal_valid  = tbl[i].pv;
            pal_index  = tbl[i].idx;
            pal_rgb    = tbl[i].rgb;
        end

        // Reset during the SCALE slot with a palette entry queued
        mode_valid = 1'b1; pal_valid = 1'b1; pal_index = 8'hAA; pal_rgb = 24'h555555;
        @(negedge clk);
        mode_valid = 1'b0; pal_valid = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (control_op == 8'd4) found = 1'b1;
        end
        chk("abort.scale_reached", 32'(found), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("abort.async_op", 32'(control_op), 32'd0);
        chk("abort.async_data", control_data, 32'd0);
        chk("abort.async_busy", 32'(busy), 32'd1);
        chk("abort.async_mode_ready", 32'(mode_ready), 32'd0);
        chk("abort.async_pal_ready", 32'(pal_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk); chk("abort.init_op0", 32'(control_op), 32'd5);
        chk("abort.init_data", control_data, 32'd0);
        @(negedge clk); chk("abort.init_op1", 32'(control_op), 32'd5);
        @(negedge clk); chk("abort.init_nop", 32'(control_op), 32'd0);
        @(negedge clk);
        chk("abort.idle_mode_ready", 32'(mode_ready), 32'd1);
        chk("abort.fifo_empty_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("abort.no_pal_slot", 32'(control_op), 32'd0);

        // Simultaneous push and pop with three entries queued
        exp_v[0] = 32'h110B0B0B; exp_v[1] = 32'h120C0C0C; exp_v[2] = 32'h130D0D0D;
        mode_valid = 1'b1;
        @(negedge clk);
        mode_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pal_valid = 1'b1;
            pal_index = 8'h10 + 8'(i);
            pal_rgb   = {3{8'h0A + 8'(i)}};
            @(negedge clk);
        end
        pal_valid = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (mode_ready) found = 1'b1;
        end
        chk("pp.idle_reached", 32'(found), 32'd1);
        chk("pp.busy_count3", 32'(busy), 32'd1);
        chk("pp.pal_ready_count3", 32'(pal_ready), 32'd1);
        pal_valid = 1'b1; pal_index = 8'h13; pal_rgb = 24'h0D0D0D;
        @(negedge clk);
        pal_valid = 1'b0;
        chk("pp.first_op", 32'(control_op), 32'd3);
        chk("pp.first_data", control_data, 32'h100A0A0A);
        chk("pp.pal_ready_after", 32'(pal_ready), 32'd1);
        got = 0;
        prev_op = control_op;
        for (int n = 0; n < 40 && got < 3; n++) begin
            @(negedge clk);
            if (control_op == 8'd3 && prev_op != 8'd3) begin
                got_v[got] = control_data;
                got++;
            end
            prev_op = control_op;
        end
        chk("pp.slot_count", 32'(got), 32'd3);
        for (int k = 0; k < got; k++) chk($sformatf("pp.order%0d", k), got_v[k], exp_v[k]);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rand.op", 32'(control_op), 32'(m_op));
            chk("rand.data", control_data, m_data);
            chk("rand.mode_ready", 32'(mode_ready), 32'((mq.size() == 0) && !m_show && !m_init));
            chk("rand.pal_ready", 32'(pal_ready), 32'(!m_init && (pq.size() < DEPTH)));
            chk("rand.busy", 32'(busy), 32'(m_init || (mq.size() != 0) || m_show || (pq.size() != 0)));
            aresetn        = ($urandom_range(0, 299) != 0);
            mode_valid     = ($urandom_range(0, 5) == 0);
            pal_valid      = ($urandom_range(0, 1) == 1);
            pal_index      = 8'($urandom());
            pal_rgb        = 24'($urandom());
            mode_dims      = $urandom();
            mode_max       = $urandom();
            mode_hs        = $urandom();
            mode_vs        = $urandom();
            mode_colormode = 2'($urandom());
            mode_scale     = 2'($urandom());
            mode_thresh    = 16'($urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
